// File: rtl/conv1_sched.sv
// rtl/conv1_sched.sv - round-robin lane scheduler and result sequencer for the conv1 filter bank
module conv1_sched #(
  parameter int NUM_LANES = 8,
  parameter int LANE_LAT  = 9,
  parameter int OUT_W     = 26,
  parameter int OUT_H     = 26
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         win_valid,
  output logic                         win_ready,
  output logic [NUM_LANES-1:0]         lane_valid,
  output logic                         res_capture,
  output logic [$clog2(NUM_LANES)-1:0] res_sel,
  output logic                         out_valid,
  output logic [7:0]                   out_row,
  output logic [7:0]                   out_col,
  output logic                         out_last,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int SW    = $clog2(NUM_LANES);
  localparam int TOTAL = OUT_W * OUT_H;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [CW-1:0] TOTAL_M1 = CW'(TOTAL - 1);
  localparam logic [7:0]    COL_LAST = 8'(OUT_W - 1);
  localparam logic [7:0]    ROW_LAST = 8'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q;
  logic [CW-1:0]       issue_cnt_q;
  logic [CW-1:0]       emit_cnt_q;
  logic [7:0]          row_q;
  logic [7:0]          col_q;
  logic [LANE_LAT-1:0] pipe_v_q;
  logic [SW-1:0]       pipe_lane_q [LANE_LAT];
  logic                out_valid_q;

  logic accept;
  logic enter_run;
  logic flush;

  // Ready depends only on registered state and abort, never on win_valid.
  assign win_ready = (state_q == RUN) && (issue_cnt_q != TOTAL_C) && !abort;
  assign accept    = win_valid && win_ready;
  assign enter_run = (state_q == IDLE) && start && !abort;
  assign flush     = abort && (state_q != IDLE);

  assign res_capture = pipe_v_q[LANE_LAT-1];
  assign res_sel     = pipe_lane_q[LANE_LAT-1];
  assign out_valid   = out_valid_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_last    = out_valid_q && (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state decode plus the combinational strobes; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    lane_valid = '0;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    if (accept) lane_valid[slot_q] = 1'b1;
    case (state_q)
      IDLE:    if (enter_run) state_d = RUN;
      RUN:     if (accept && (issue_cnt_q == TOTAL_M1)) state_d = DRAIN;
      DRAIN:   if (out_valid_q && (emit_cnt_q == TOTAL_M1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lane slot, issue/emit counters and output coordinates; all cleared on entry to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else if (enter_run) begin
      slot_q      <= '0;
      issue_cnt_q <= '0;
      emit_cnt_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      if (accept) begin
        slot_q      <= slot_q + 1'b1;
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (out_valid_q) begin
        emit_cnt_q <= emit_cnt_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? 8'd0 : row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
    end
  end

  // Latency pipe mirrors the lanes' fixed latency so the finishing lane is known without feedback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < LANE_LAT; i++) pipe_lane_q[i] <= '0;
    end else if (flush) begin
      pipe_v_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pipe_v_q[0]    <= accept;
      pipe_lane_q[0] <= slot_q;
      for (int i = 1; i < LANE_LAT; i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_lane_q[i] <= pipe_lane_q[i-1];
      end
      out_valid_q <= pipe_v_q[LANE_LAT-1];
    end
  end

endmodule

// File: tb/tb_conv1_sched.sv
// tb/tb_conv1_sched.sv - scoreboard bench for conv1_sched with a frame-level reference model
module tb_conv1_sched;

  localparam int NL    = 8;
  localparam int LAT   = 9;
  localparam int W     = 4;
  localparam int H     = 3;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic [NL-1:0] lane_valid;
  logic          res_capture;
  logic [2:0]    res_sel;
  logic          out_valid;
  logic [7:0]    out_row;
  logic [7:0]    out_col;
  logic          out_last;
  logic          busy;
  logic          frame_done;

  conv1_sched #(.NUM_LANES(NL), .LANE_LAT(LAT), .OUT_W(W), .OUT_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .win_valid(win_valid), .win_ready(win_ready), .lane_valid(lane_valid),
    .res_capture(res_capture), .res_sel(res_sel), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int lane; int t; } cap_t;
  typedef struct { int row; int col; int last; int t; } out_t;
  cap_t cap_q[$];
  out_t out_q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Frame-level model: phase 0 idle, 1 accepting, 2 waiting for the tail to drain.
  int            m_phase   = 0;
  int            issued    = 0;
  int            m_done_cyc = 0;
  bit            flush_req = 0;
  logic          exp_wr    = 1'b0;
  logic          exp_busy  = 1'b0;
  logic          exp_fd    = 1'b0;
  logic [NL-1:0] exp_lv    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_res", {res_capture, res_sel}, 0);
    chk("rst_out", {out_valid, out_last, out_row, out_col}, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  // One clock of stimulus; the model predicts this cycle's outputs and queues future results.
  task automatic step(input logic s, input logic a, input logic v);
    int  c;
    bit  acc;
    @(posedge clk);
    #1;
    start = s; abort = a; win_valid = v;
    c        = cyc;
    exp_busy = (m_phase != 0);
    exp_fd   = (m_phase == 2) && (c == m_done_cyc);
    exp_wr   = (m_phase == 1) && (issued < TOTAL) && !a;
    acc      = exp_wr && v;
    exp_lv   = '0;
    if (acc) begin
      exp_lv[issued % NL] = 1'b1;
      cap_q.push_back('{lane: issued % NL, t: c + LAT});
      out_q.push_back('{row: issued / W, col: issued % W,
                        last: (issued == TOTAL - 1), t: c + LAT + 1});
      issued++;
    end
    if (a && m_phase != 0) begin
      m_phase   = 0;
      flush_req = 1;
    end else if (m_phase == 0 && s && !a) begin
      m_phase = 1;
      issued  = 0;
    end else if (m_phase == 1 && acc && issued == TOTAL) begin
      m_phase    = 2;
      m_done_cyc = c + LAT + 2;
    end else if (m_phase == 2 && c == m_done_cyc) begin
      m_phase = 0;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; win_valid = 1'b0;
    #1;
    chk_reset_outputs();
    m_phase = 0; issued = 0; flush_req = 0;
    cap_q.delete(); out_q.delete();
    exp_wr = 0; exp_busy = 0; exp_fd = 0; exp_lv = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode 0: win_valid held high, 1: alternating, 2: random with stray start pulses.
  // stop_at >= 0 interrupts the frame after that many cycles by abort or async reset.
  task automatic run_frame(input int mode, input int stop_at, input bit use_reset);
    int   n = 0;
    bit   stopped = 0;
    logic v, s;
    step(1'b1, 1'b0, 1'b1);
    while (m_phase != 0 && n < 400) begin
      if (stop_at >= 0 && n == stop_at) begin
        if (use_reset) async_reset();
        else step(1'b0, 1'b1, 1'(($urandom_range(0, 1))));
        stopped = 1;
        break;
      end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((n % 2) == 0) : 1'($urandom_range(0, 1));
      s = (mode == 2) ? 1'($urandom_range(0, 7) == 0) : 1'b0;
      step(s, 1'b0, v);
      n++;
    end
    if (!stopped) chk("frame_complete_within_bound", (n < 400), 1);
    repeat (LAT + 4) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: per-cycle strobes against the model, results popped from the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_cap, exp_ov;
      chk("win_ready", win_ready, exp_wr);
      chk("lane_valid", lane_valid, exp_lv);
      chk("busy", busy, exp_busy);
      chk("frame_done", frame_done, exp_fd);
      exp_cap = (cap_q.size() > 0) && (cap_q[0].t == cyc);
      chk("res_capture", res_capture, exp_cap);
      if (exp_cap) begin
        chk("res_sel", res_sel, cap_q[0].lane);
        void'(cap_q.pop_front());
      end
      exp_ov = (out_q.size() > 0) && (out_q[0].t == cyc);
      chk("out_valid", out_valid, exp_ov);
      chk("out_last", out_last, exp_ov ? out_q[0].last : 0);
      if (exp_ov) begin
        chk("out_row", out_row, out_q[0].row);
        chk("out_col", out_col, out_q[0].col);
        void'(out_q.pop_front());
      end
      if (flush_req) begin
        cap_q.delete();
        out_q.delete();
        flush_req = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    run_frame(0, -1, 0);
    run_frame(1, -1, 0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    run_frame(0, 3, 0);
    run_frame(0, -1, 0);
    run_frame(2, -1, 0);
    run_frame(0, 15, 1);
    run_frame(2, -1, 0);
    for (int k = 0; k < 8; k++)
      run_frame(2, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
    run_frame(1, -1, 0);

    chk("cap_queue_drained", cap_q.size(), 0);
    chk("out_queue_drained", out_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
